// File: rtl/low_priority_encoder_8_3.sv
// Registered 8-to-3 low-priority encoder: lowest-numbered asserted request wins.
// Define LPE_INPUT_REG_EN to add an input register stage (2-cycle latency).
module low_priority_encoder_8_3 (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic       Data_0_In,
    input  logic       Data_1_In,
    input  logic       Data_2_In,
    input  logic       Data_3_In,
    input  logic       Data_4_In,
    input  logic       Data_5_In,
    input  logic       Data_6_In,
    input  logic       Data_7_In,
    output logic [2:0] Encoded_Value_Out,
    output logic       Valid_Out
);

    logic [7:0] data_bus;
    logic [7:0] enc_src;
    logic [2:0] code;
    logic       any_req;

    assign data_bus = {Data_7_In, Data_6_In, Data_5_In, Data_4_In,
                       Data_3_In, Data_2_In, Data_1_In, Data_0_In};

`ifdef LPE_INPUT_REG_EN
    logic [7:0] data_q;

    // Cleared stage reads as "no request" until the first real sample lands.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q <= '0;
        end else begin
            data_q <= data_bus;
        end
    end

    assign enc_src = data_q;
`else
    assign enc_src = data_bus;
`endif

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        code    = 3'd0;
        any_req = |enc_src;
        for (int i = 7; i >= 0; i--) begin
            if (enc_src[i]) begin
                code = 3'(i);
            end
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            Encoded_Value_Out <= 3'd0;
            Valid_Out         <= 1'b0;
        end else begin
            Encoded_Value_Out <= code;
            Valid_Out         <= any_req;
        end
    end

endmodule

// File: tb/tb_low_priority_encoder_8_3.sv
// Self-checking bench for low_priority_encoder_8_3.
// Build with +define+LPE_INPUT_REG_EN to check the 2-cycle variant.
module tb_low_priority_encoder_8_3;

`ifdef LPE_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [2:0] enc;
    logic       vld;

    int checks   = 0;
    int failures = 0;

    // Entries are {valid, code}
    logic [3:0] sb[$];

    typedef struct {
        logic [7:0] d;
        logic [2:0] code;
        logic       valid;
    } vec_t;

    vec_t vecs[14];

    low_priority_encoder_8_3 dut (
        .Clock_In          (clk),
        .Reset_In          (rst),
        .Data_0_In         (data[0]),
        .Data_1_In         (data[1]),
        .Data_2_In         (data[2]),
        .Data_3_In         (data[3]),
        .Data_4_In         (data[4]),
        .Data_5_In         (data[5]),
        .Data_6_In         (data[6]),
        .Data_7_In         (data[7]),
        .Encoded_Value_Out (enc),
        .Valid_Out         (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic [7:0] d);
        int idx;
        idx = -1;
        for (int i = 0; i < 8; i++) begin
            if (idx < 0 && d[i]) idx = i;
        end
        if (idx < 0) return 4'b0000;
        return {1'b1, 3'(idx)};
    endfunction

    task automatic check(input string name, input logic [2:0] want_code,
                         input logic want_vld);
        checks++;
        if (enc !== want_code || vld !== want_vld) begin
            failures++;
            $display("FAIL %s: got code=%0d valid=%0b, want code=%0d valid=%0b",
                     name, enc, vld, want_code, want_vld);
        end
    endtask

    task automatic prefill();
        sb.delete();
        for (int i = 0; i < LAT - 1; i++) sb.push_back(4'b0000);
    endtask

    // Drive between edges, push expectation at the edge, compare 1 ns later.
    task automatic step(input string name, input logic [7:0] d,
                        input logic [3:0] exp);
        logic [3:0] e;
        data = d;
        @(posedge clk);
        sb.push_back(exp);
        #1;
        if (sb.size() >= LAT) begin
            e = sb.pop_front();
            check(name, e[2:0], e[3]);
        end
    endtask

    initial begin
        logic [7:0] r;

        vecs[0]  = '{8'b0000_0001, 3'd0, 1'b1};
        vecs[1]  = '{8'b0000_0010, 3'd1, 1'b1};
        vecs[2]  = '{8'b0000_0100, 3'd2, 1'b1};
        vecs[3]  = '{8'b0000_1000, 3'd3, 1'b1};
        vecs[4]  = '{8'b0001_0000, 3'd4, 1'b1};
        vecs[5]  = '{8'b0010_0000, 3'd5, 1'b1};
        vecs[6]  = '{8'b0100_0000, 3'd6, 1'b1};
        vecs[7]  = '{8'b1000_0000, 3'd7, 1'b1};
        vecs[8]  = '{8'b1111_1000, 3'd3, 1'b1};
        vecs[9]  = '{8'b1000_0001, 3'd0, 1'b1};
        vecs[10] = '{8'b1100_0000, 3'd6, 1'b1};
        vecs[11] = '{8'b0000_0000, 3'd0, 1'b0};
        vecs[12] = '{8'b0000_0001, 3'd0, 1'b1};
        vecs[13] = '{8'b1010_0100, 3'd2, 1'b1};

        rst  = 1'b0;
        data = 8'hFF;
        #1 rst = 1'b1;
        #1 check("reset_async", 3'd0, 1'b0);
        @(posedge clk);
        #1 check("reset_hold", 3'd0, 1'b0);
        #4 rst = 1'b0;

        prefill();
        step("first_after_reset", 8'hFF, {1'b1, 3'd0});

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].d, {vecs[i].valid, vecs[i].code});
        end

        // Glitch between edges must not reach the output.
        data = 8'b0000_0001;
        #3;
        step("glitch", 8'b0100_0000, {1'b1, 3'd6});
        step("empty_again", 8'h00, 4'b0000);

        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom);
            step($sformatf("rand%0d", i), r, model(r));
        end

        // Mid-stream reset discards in-flight samples.
        data = 8'hFF;
        #2 rst = 1'b1;
        #1 check("midreset_async", 3'd0, 1'b0);
        @(posedge clk);
        #1 check("midreset_hold", 3'd0, 1'b0);
        #2 rst = 1'b0;
        prefill();

        for (int i = 10; i < 20; i++) begin
            r = 8'($urandom);
            step($sformatf("rand%0d", i), r, model(r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
